// File: rtl/mem_port_arbiter_pkg.sv
// core_mem_pkg: shared state encoding and port-select constants for the memory port arbiter
package core_mem_pkg;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        I_BUSY = 2'd1,
        D_BUSY = 2'd2
    } state_t;

    localparam logic PORT_I = 1'b0;
    localparam logic PORT_D = 1'b1;

endpackage

// File: rtl/mem_port_arbiter_if.sv
// mem_port_arbiter_if: fetch, data and memory-side signals of the shared memory port
interface mem_port_arbiter_if #(
    parameter int ADDR_W = 32,
    parameter int DATA_W = 32
);
    logic              IReq;
    logic [ADDR_W-1:0] IAddr;
    logic [DATA_W-1:0] IRData;
    logic              IValid;
    logic              IStall;
    logic              DRead;
    logic              DWrite;
    logic [ADDR_W-1:0] DAddr;
    logic [DATA_W-1:0] DWData;
    logic [DATA_W-1:0] DRData;
    logic              DValid;
    logic              DStall;
    logic              MemReq;
    logic              MemWe;
    logic [ADDR_W-1:0] MemAddr;
    logic [DATA_W-1:0] MemWData;
    logic [DATA_W-1:0] MemRData;
    logic              MemReady;
    logic              Err;

    modport slave (
        input  IReq, IAddr, DRead, DWrite, DAddr, DWData, MemReady, MemRData,
        output IRData, IValid, IStall, DRData, DValid, DStall, MemReq, MemWe, MemAddr, MemWData, Err
    );

    modport master (
        output IReq, IAddr, DRead, DWrite, DAddr, DWData, MemReady, MemRData,
        input  IRData, IValid, IStall, DRData, DValid, DStall, MemReq, MemWe, MemAddr, MemWData, Err
    );

endinterface

// File: rtl/mem_port_arbiter_wait_timer.sv
// arb_wait_timer: counts busy cycles after a grant and flags a transaction the memory never acknowledges
module arb_wait_timer #(
    parameter int TIMEOUT = 255
) (
    input  logic CLK,
    input  logic RST,
    input  logic start,
    input  logic ready,
    output logic expire
);

    localparam int W = TIMEOUT > 1 ? $clog2(TIMEOUT) : 1;

    logic [W-1:0] cnt;
    logic         run;

    assign expire = TIMEOUT != 0 && run && !ready && cnt == W'(TIMEOUT - 1);

    // Restart on each grant, count while the transaction is outstanding
    always_ff @(posedge CLK or negedge RST) begin
        if (!RST) begin
            cnt <= '0;
            run <= 1'b0;
        end else if (start) begin
            cnt <= '0;
            run <= 1'b1;
        end else if (run) begin
            cnt <= cnt + W'(1);
            if (ready || expire) run <= 1'b0;
        end
    end

endmodule

// File: rtl/mem_port_arbiter.sv
// mem_port_arbiter: shares one single-port memory between fetch and data ports, data first with fetch anti-starvation
import core_mem_pkg::*;

module mem_port_arbiter #(
    parameter int ADDR_W       = 32,
    parameter int DATA_W       = 32,
    parameter int STARVE_LIMIT = 4,
    parameter int TIMEOUT      = 255
) (
    input logic               CLK,
    input logic               RST,
    mem_port_arbiter_if.slave bus
);

    state_t     state, state_nx;
    logic [3:0] starve_cnt;
    logic       dreq, grant_i, grant_d, grant, sel, busy, done, expire;

    // Arbitration in IDLE and next-state decode; a saturated starve count hands the slot to fetch
    always_comb begin
        dreq     = bus.DRead | bus.DWrite;
        grant_d  = state == IDLE && dreq && !(bus.IReq && starve_cnt == 4'(STARVE_LIMIT));
        grant_i  = state == IDLE && bus.IReq && !grant_d;
        grant    = grant_i | grant_d;
        sel      = grant_d ? PORT_D : PORT_I;
        busy     = state != IDLE;
        done     = busy && (bus.MemReady || expire);
        state_nx = grant_d ? D_BUSY : grant_i ? I_BUSY : done ? IDLE : state;
    end

    arb_wait_timer #(.TIMEOUT(TIMEOUT)) u_timer (
        .CLK    (CLK),
        .RST    (RST),
        .start  (grant),
        .ready  (bus.MemReady),
        .expire (expire)
    );

    assign bus.IStall = bus.IReq & ~bus.IValid;
    assign bus.DStall = dreq & ~bus.DValid;

    // State register; reset abandons any transaction in flight
    always_ff @(posedge CLK or negedge RST) begin
        if (!RST) state <= IDLE;
        else      state <= state_nx;
    end

    // Latch the granted request, return data and pulse Valid on completion or abort
    always_ff @(posedge CLK or negedge RST) begin
        if (!RST) begin
            bus.MemReq   <= 1'b0;
            bus.MemWe    <= 1'b0;
            bus.MemAddr  <= {ADDR_W{1'b0}};
            bus.MemWData <= {DATA_W{1'b0}};
            bus.IRData   <= {DATA_W{1'b0}};
            bus.DRData   <= {DATA_W{1'b0}};
            bus.IValid   <= 1'b0;
            bus.DValid   <= 1'b0;
            bus.Err      <= 1'b0;
            starve_cnt   <= 4'd0;
        end else begin
            bus.IValid <= done && state == I_BUSY;
            bus.DValid <= done && state == D_BUSY;
            if (grant) begin
                bus.MemReq   <= 1'b1;
                bus.MemWe    <= sel == PORT_D && bus.DWrite;
                bus.MemAddr  <= sel == PORT_D ? bus.DAddr : bus.IAddr;
                bus.MemWData <= sel == PORT_D ? bus.DWData : {DATA_W{1'b0}};
            end else if (done) begin
                bus.MemReq <= 1'b0;
            end
            if (done && state == I_BUSY) bus.IRData <= bus.MemReady ? bus.MemRData : {DATA_W{1'b0}};
            if (done && state == D_BUSY && !bus.MemWe) bus.DRData <= bus.MemReady ? bus.MemRData : {DATA_W{1'b0}};
            if (expire) bus.Err <= 1'b1;
            if (grant_i) starve_cnt <= 4'd0;
            else if (grant_d) starve_cnt <= !bus.IReq ? 4'd0 : starve_cnt == 4'(STARVE_LIMIT) ? starve_cnt : starve_cnt + 4'd1;
        end
    end

endmodule
